// File: rtl/audiodac_pkg.sv
// ---------------------------------------------------------------------------
// audiodac_pkg
// Shared definitions for the audiodac blocks.
//   ST_W           width of the sequencer state encoding
//   dac_state_e    sequencer states OFF/PRECHG/FADEIN/RUN/FADEOUT (0..4)
//   idle_pattern() zero-differential, mid-rail idle drive {p, n} from toggle t
// ---------------------------------------------------------------------------
package audiodac_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_OFF     = 3'd0,
        ST_PRECHG  = 3'd1,
        ST_FADEIN  = 3'd2,
        ST_RUN     = 3'd3,
        ST_FADEOUT = 3'd4
    } dac_state_e;

    // Both legs follow the same toggle: differential stays at zero while the
    // common mode averages to mid-rail.
    function automatic logic [1:0] idle_pattern(input logic t);
        return {t, t};
    endfunction

endpackage

// File: rtl/audiodac_ramp_blend.sv
// ---------------------------------------------------------------------------
// audiodac_ramp_blend
// Holds the ramp level r and the blend accumulator acc. Each accumulate step
// forms {carry, acc} = acc + r; the carry picks the modulator bitstream over
// the idle pattern, so the data fraction tracks r / 2^RAMP_BITS.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   init                 load r = 0, acc = 0
//   acc_en               commit acc + r into acc (one modulator tick)
//   r_inc / r_dec        step r up / down, saturating at max / 0
//   data_only            force bitstream through (RUN)
//   ds_p, ds_n           modulator bitstream legs
//   idle_t               idle toggle
//   r                    current ramp level
//   mix_p, mix_n         selected drive for the current step (combinational)
// ---------------------------------------------------------------------------
module audiodac_ramp_blend
    import audiodac_pkg::*;
#(
    parameter int RAMP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 acc_en,
    input  logic                 r_inc,
    input  logic                 r_dec,
    input  logic                 data_only,
    input  logic                 ds_p,
    input  logic                 ds_n,
    input  logic                 idle_t,
    output logic [RAMP_BITS-1:0] r,
    output logic                 mix_p,
    output logic                 mix_n
);

    localparam logic [RAMP_BITS-1:0] R_MAX = {RAMP_BITS{1'b1}};

    logic [RAMP_BITS-1:0] acc;
    logic [RAMP_BITS:0]   sum;
    logic                 carry;
    logic [1:0]           idle;

    assign sum   = {1'b0, acc} + {1'b0, r};
    assign carry = sum[RAMP_BITS];
    assign idle  = idle_pattern(idle_t);

    always_comb begin
        mix_p = idle[1];
        mix_n = idle[0];
        if (data_only || carry) begin
            mix_p = ds_p;
            mix_n = ds_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= '0;
            acc <= '0;
        end else if (init) begin
            r   <= '0;
            acc <= '0;
        end else begin
            if (acc_en) acc <= sum[RAMP_BITS-1:0];
            // Saturate at both ends so a late step can never wrap the level.
            if (r_inc && (r != R_MAX))   r <= r + 1'b1;
            else if (r_dec && (r != '0)) r <= r - 1'b1;
        end
    end

endmodule

// File: rtl/audiodac_drv_seq.sv
// ---------------------------------------------------------------------------
// audiodac_drv_seq
// Pop-free power sequencer for the audiodac_drv output driver: precharge with
// the idle pattern, fade the bitstream in, run, fade out; aborts to silence
// on sustained modulator underrun (sticky err_o).
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   en_i                 play request (level)
//   ds_valid_i           modulator tick strobe; ramp/count steps happen on it
//   ds_p_i, ds_n_i       modulator bitstream legs
//   underrun_i           sample source starved this tick
//   err_clr_i            clears err_o (a coincident set wins)
//   drv_p_o, drv_n_o     driver in_p / in_n (registered, hold between ticks)
//   drv_hi_o             driver enable
//   running_o            state is RUN
//   state_o              current state (debug)
//   err_o                sticky underrun-abort flag
// Handshake: ds_valid_i is a strobe with no back-pressure; data and
// underrun_i are only looked at in a cycle where ds_valid_i is 1.
// ---------------------------------------------------------------------------
module audiodac_drv_seq
    import audiodac_pkg::*;
#(
    parameter int PRECHG_TICKS   = 1024,
    parameter int RAMP_BITS      = 8,
    parameter int RAMP_DIV       = 16,
    parameter int UNDERRUN_LIMIT = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            en_i,
    input  logic            ds_valid_i,
    input  logic            ds_p_i,
    input  logic            ds_n_i,
    input  logic            underrun_i,
    input  logic            err_clr_i,
    output logic            drv_p_o,
    output logic            drv_n_o,
    output logic            drv_hi_o,
    output logic            running_o,
    output logic [ST_W-1:0] state_o,
    output logic            err_o
);

    localparam int PC_W  = $clog2(PRECHG_TICKS + 1);
    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam int UR_W  = $clog2(UNDERRUN_LIMIT + 1);

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRECHG_TICKS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [UR_W-1:0]  UR_LAST  = UR_W'(UNDERRUN_LIMIT - 1);

    dac_state_e           state_q, state_d;
    logic [PC_W-1:0]      pc_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [UR_W-1:0]      ur_cnt;
    logic                 idle_t;
    logic                 en_eff;
    logic                 div_wrap;
    logic                 blend_init, acc_en, r_inc, r_dec, err_set;
    logic [RAMP_BITS-1:0] r;
    logic                 mix_p, mix_n;
    logic [1:0]           idle;

    // A pending error overrides the play request.
    assign en_eff   = en_i && !err_o;
    assign div_wrap = ds_valid_i && (div_cnt == DIV_LAST);
    assign idle     = idle_pattern(idle_t);
    assign state_o  = state_q;

    // Enable-driven transitions take effect on the next clock; ramp and count
    // steps only on ticks. When en_i changes on a tick, that tick still drives
    // the output under the old state but does not step r.
    always_comb begin
        state_d    = state_q;
        blend_init = 1'b0;
        acc_en     = 1'b0;
        r_inc      = 1'b0;
        r_dec      = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (en_eff) state_d = ST_PRECHG;
            end
            ST_PRECHG: begin
                if (!en_eff) begin
                    state_d = ST_OFF;
                end else if (ds_valid_i && (pc_cnt == PC_LAST)) begin
                    state_d    = ST_FADEIN;
                    blend_init = 1'b1;
                end
            end
            ST_FADEIN: begin
                acc_en = ds_valid_i;
                if (!en_eff) begin
                    state_d = ST_FADEOUT;
                end else if (div_wrap) begin
                    if (&r) state_d = ST_RUN;
                    else    r_inc   = 1'b1;
                end
            end
            ST_RUN: begin
                if (ds_valid_i && underrun_i && (ur_cnt == UR_LAST)) begin
                    state_d = ST_FADEOUT;
                    err_set = 1'b1;
                end else if (!en_eff) begin
                    state_d = ST_FADEOUT;
                end
            end
            ST_FADEOUT: begin
                acc_en = ds_valid_i;
                if (en_eff) begin
                    state_d = ST_FADEIN;
                end else if (div_wrap) begin
                    if (r == '0) state_d = ST_OFF;
                    else         r_dec   = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_OFF;
            pc_cnt    <= '0;
            div_cnt   <= '0;
            ur_cnt    <= '0;
            idle_t    <= 1'b0;
            err_o     <= 1'b0;
            drv_p_o   <= 1'b0;
            drv_n_o   <= 1'b0;
            drv_hi_o  <= 1'b0;
            running_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ds_valid_i) idle_t <= ~idle_t;

            if ((state_q == ST_PRECHG) && (state_d == ST_PRECHG)) begin
                if (ds_valid_i) pc_cnt <= pc_cnt + 1'b1;
            end else begin
                pc_cnt <= '0;
            end

            // Each state entry starts a fresh ramp-step interval.
            if (state_d != state_q)  div_cnt <= '0;
            else if (acc_en)         div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;

            if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
                if (ds_valid_i) ur_cnt <= underrun_i ? ur_cnt + 1'b1 : '0;
            end else begin
                ur_cnt <= '0;
            end

            if (err_set)        err_o <= 1'b1;
            else if (err_clr_i) err_o <= 1'b0;

            if (state_d == ST_OFF) begin
                drv_p_o  <= 1'b0;
                drv_n_o  <= 1'b0;
                drv_hi_o <= 1'b0;
            end else begin
                drv_hi_o <= 1'b1;
                if (ds_valid_i) begin
                    case (state_q)
                        ST_PRECHG: begin
                            drv_p_o <= idle[1];
                            drv_n_o <= idle[0];
                        end
                        ST_FADEIN, ST_RUN, ST_FADEOUT: begin
                            drv_p_o <= mix_p;
                            drv_n_o <= mix_n;
                        end
                        default: ;
                    endcase
                end
            end

            running_o <= (state_d == ST_RUN);
        end
    end

    audiodac_ramp_blend #(
        .RAMP_BITS (RAMP_BITS)
    ) u_blend (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .init      (blend_init),
        .acc_en    (acc_en),
        .r_inc     (r_inc),
        .r_dec     (r_dec),
        .data_only (state_q == ST_RUN),
        .ds_p      (ds_p_i),
        .ds_n      (ds_n_i),
        .idle_t    (idle_t),
        .r         (r),
        .mix_p     (mix_p),
        .mix_n     (mix_n)
    );

endmodule

// File: tb/tb_audiodac_drv_seq.sv
// ---------------------------------------------------------------------------
// tb_audiodac_drv_seq
// Directed bench for audiodac_drv_seq with PRECHG_TICKS=8, RAMP_BITS=3,
// RAMP_DIV=2, UNDERRUN_LIMIT=4 and a modulator tick every 4th clock.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed a tick.
// ---------------------------------------------------------------------------
module tb_audiodac_drv_seq;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       ds_valid_i = 1'b0;
    logic       ds_p_i = 1'b1;
    logic       ds_n_i = 1'b0;
    logic       underrun_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic       drv_p_o, drv_n_o, drv_hi_o, running_o, err_o;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] S_OFF = 3'd0, S_PRE = 3'd1, S_FIN = 3'd2,
                           S_RUN = 3'd3, S_FOUT = 3'd4;

    // Carry sequence of acc + r for r = 0,0,1,1,..,7,7 starting at acc = 0.
    bit fadein_pat[16]  = '{0,0,0,0,0,0,1,0,1,0,1,0,1,1,1,1};
    // Same for r = 7,7,6,6,..,0 starting at acc = 0; the 16th step goes OFF.
    bit fadeout_pat[15] = '{0,1,1,1,0,1,1,0,0,1,0,0,0,1,0};

    always #5 wb_clk_i = ~wb_clk_i;

    audiodac_drv_seq #(
        .PRECHG_TICKS   (8),
        .RAMP_BITS      (3),
        .RAMP_DIV       (2),
        .UNDERRUN_LIMIT (4)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .en_i       (en_i),
        .ds_valid_i (ds_valid_i),
        .ds_p_i     (ds_p_i),
        .ds_n_i     (ds_n_i),
        .underrun_i (underrun_i),
        .err_clr_i  (err_clr_i),
        .drv_p_o    (drv_p_o),
        .drv_n_o    (drv_n_o),
        .drv_hi_o   (drv_hi_o),
        .running_o  (running_o),
        .state_o    (state_o),
        .err_o      (err_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // One modulator tick spaced 4 clocks from the previous one; returns on
    // the falling edge where the tick's result is visible.
    task automatic do_tick();
        repeat (3) @(negedge wb_clk_i);
        ds_valid_i = 1'b1;
        @(negedge wb_clk_i);
        ds_valid_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 12; i++) do_tick();
        repeat (2) @(negedge wb_clk_i);
        checks++; if (state_o !== S_OFF) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
        checks++; if ({drv_p_o, drv_n_o, drv_hi_o} !== 3'b000) begin errors++; $display("FAIL reset_drv: got %b want 000", {drv_p_o, drv_n_o, drv_hi_o}); end
        checks++; if ({err_o, running_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {err_o, running_o}); end
    endtask

    task automatic test_power_up();
        logic prev_p;
        prev_p = 1'b0;
        ds_p_i = 1'b1; ds_n_i = 1'b0;
        en_i = 1'b1;
        @(negedge wb_clk_i);
        checks++; if (state_o !== S_PRE) begin errors++; $display("FAIL pu_enter_state: got %0d want 1", state_o); end
        checks++; if ({drv_hi_o, drv_p_o, drv_n_o} !== 3'b100) begin errors++; $display("FAIL pu_enter_drv: got %b want 100", {drv_hi_o, drv_p_o, drv_n_o}); end
        for (int i = 0; i < 8; i++) begin
            do_tick();
            checks++; if (drv_p_o !== drv_n_o) begin errors++; $display("FAIL prechg_idle tick %0d: p=%b n=%b want equal", i, drv_p_o, drv_n_o); end
            if (i > 0) begin
                checks++; if (drv_p_o !== ~prev_p) begin errors++; $display("FAIL prechg_toggle tick %0d: got %b want %b", i, drv_p_o, ~prev_p); end
            end
            prev_p = drv_p_o;
            checks++; if (state_o !== ((i == 7) ? S_FIN : S_PRE)) begin errors++; $display("FAIL prechg_state tick %0d: got %0d want %0d", i, state_o, (i == 7) ? S_FIN : S_PRE); end
        end
        for (int i = 0; i < 16; i++) begin
            do_tick();
            if (fadein_pat[i]) begin
                checks++; if ({drv_p_o, drv_n_o} !== 2'b10) begin errors++; $display("FAIL fadein_data tick %0d: got %b want 10", i, {drv_p_o, drv_n_o}); end
            end else begin
                checks++; if (drv_p_o !== drv_n_o) begin errors++; $display("FAIL fadein_idle tick %0d: p=%b n=%b want equal", i, drv_p_o, drv_n_o); end
            end
            checks++; if (state_o !== ((i == 15) ? S_RUN : S_FIN)) begin errors++; $display("FAIL fadein_state tick %0d: got %0d want %0d", i, state_o, (i == 15) ? S_RUN : S_FIN); end
        end
        checks++; if (running_o !== 1'b1) begin errors++; $display("FAIL run_flag: got %b want 1", running_o); end
        ds_p_i = 1'b0; ds_n_i = 1'b1;
        do_tick();
        checks++; if ({drv_p_o, drv_n_o, drv_hi_o} !== 3'b011) begin errors++; $display("FAIL run_data01: got %b want 011", {drv_p_o, drv_n_o, drv_hi_o}); end
        ds_p_i = 1'b1; ds_n_i = 1'b0;
        do_tick();
        checks++; if ({drv_p_o, drv_n_o} !== 2'b10) begin errors++; $display("FAIL run_data10: got %b want 10", {drv_p_o, drv_n_o}); end
    endtask

    task automatic test_power_down();
        en_i = 1'b0;
        @(negedge wb_clk_i);
        checks++; if ({state_o, drv_hi_o, running_o} !== {S_FOUT, 2'b10}) begin errors++; $display("FAIL pd_enter: got st=%0d hi=%b run=%b want st=4 hi=1 run=0", state_o, drv_hi_o, running_o); end
        for (int i = 0; i < 16; i++) begin
            do_tick();
            if (i < 15) begin
                if (fadeout_pat[i]) begin
                    checks++; if ({drv_p_o, drv_n_o} !== 2'b10) begin errors++; $display("FAIL fadeout_data tick %0d: got %b want 10", i, {drv_p_o, drv_n_o}); end
                end else begin
                    checks++; if (drv_p_o !== drv_n_o) begin errors++; $display("FAIL fadeout_idle tick %0d: p=%b n=%b want equal", i, drv_p_o, drv_n_o); end
                end
                checks++; if (state_o !== S_FOUT) begin errors++; $display("FAIL fadeout_state tick %0d: got %0d want 4", i, state_o); end
            end else begin
                checks++; if ({state_o, drv_p_o, drv_n_o, drv_hi_o, err_o} !== {S_OFF, 4'b0000}) begin errors++; $display("FAIL pd_off: got st=%0d p=%b n=%b hi=%b err=%b want all 0", state_o, drv_p_o, drv_n_o, drv_hi_o, err_o); end
            end
        end
    endtask

    task automatic test_underrun();
        bit upat[8] = '{1,1,1,0,1,1,1,0};
        en_i = 1'b1;
        @(negedge wb_clk_i);
        for (int i = 0; i < 24; i++) do_tick();
        checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL ur_bringup: got %0d want 3", state_o); end
        for (int i = 0; i < 8; i++) begin
            underrun_i = upat[i];
            do_tick();
            checks++; if ({state_o, err_o} !== {S_RUN, 1'b0}) begin errors++; $display("FAIL ur_no_abort tick %0d: st=%0d err=%b want st=3 err=0", i, state_o, err_o); end
        end
        for (int i = 0; i < 4; i++) begin
            underrun_i = 1'b1;
            do_tick();
            if (i < 3) begin
                checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL ur_pre_abort tick %0d: got %0d want 3", i, state_o); end
            end else begin
                checks++; if ({state_o, err_o} !== {S_FOUT, 1'b1}) begin errors++; $display("FAIL ur_abort: st=%0d err=%b want st=4 err=1", state_o, err_o); end
            end
        end
        underrun_i = 1'b0;
        for (int i = 0; i < 16; i++) do_tick();
        checks++; if ({state_o, drv_hi_o, err_o} !== {S_OFF, 2'b01}) begin errors++; $display("FAIL ur_off: st=%0d hi=%b err=%b want st=0 hi=0 err=1", state_o, drv_hi_o, err_o); end
        for (int i = 0; i < 4; i++) do_tick();
        checks++; if ({state_o, drv_hi_o} !== {S_OFF, 1'b0}) begin errors++; $display("FAIL ur_hold_off: st=%0d hi=%b want st=0 hi=0", state_o, drv_hi_o); end
        err_clr_i = 1'b1;
        @(negedge wb_clk_i);
        err_clr_i = 1'b0;
        checks++; if ({err_o, state_o} !== {1'b0, S_OFF}) begin errors++; $display("FAIL ur_clear: err=%b st=%0d want err=0 st=0", err_o, state_o); end
        @(negedge wb_clk_i);
        checks++; if ({state_o, drv_hi_o} !== {S_PRE, 1'b1}) begin errors++; $display("FAIL ur_reenter: st=%0d hi=%b want st=1 hi=1", state_o, drv_hi_o); end
    endtask

    task automatic test_ramp_reverse();
        en_i = 1'b0;
        pulse_reset();
        en_i = 1'b1;
        @(negedge wb_clk_i);
        for (int i = 0; i < 15; i++) do_tick();
        checks++; if (state_o !== S_FIN) begin errors++; $display("FAIL rr_fadein: got %0d want 2", state_o); end
        en_i = 1'b0;
        @(negedge wb_clk_i);
        checks++; if (state_o !== S_FOUT) begin errors++; $display("FAIL rr_to_fadeout: got %0d want 4", state_o); end
        for (int i = 0; i < 4; i++) begin
            do_tick();
            checks++; if (state_o !== S_FOUT) begin errors++; $display("FAIL rr_fadeout tick %0d: got %0d want 4", i, state_o); end
        end
        en_i = 1'b1;
        @(negedge wb_clk_i);
        checks++; if (state_o !== S_FIN) begin errors++; $display("FAIL rr_to_fadein: got %0d want 2", state_o); end
        for (int i = 0; i < 14; i++) begin
            do_tick();
            checks++; if (state_o !== ((i == 13) ? S_RUN : S_FIN)) begin errors++; $display("FAIL rr_refade tick %0d: got %0d want %0d", i, state_o, (i == 13) ? S_RUN : S_FIN); end
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        checks++; if ({state_o, drv_p_o, drv_n_o, drv_hi_o, running_o, err_o} !== 8'b0) begin errors++; $display("FAIL rst_in_run: st=%0d p=%b n=%b hi=%b run=%b err=%b want all 0", state_o, drv_p_o, drv_n_o, drv_hi_o, running_o, err_o); end
        @(negedge wb_clk_i);
        for (int i = 0; i < 3; i++) do_tick();
        checks++; if (state_o !== S_PRE) begin errors++; $display("FAIL rst_prechg_setup: got %0d want 1", state_o); end
        pulse_reset();
        checks++; if ({state_o, drv_p_o, drv_n_o, drv_hi_o, running_o, err_o} !== 8'b0) begin errors++; $display("FAIL rst_in_prechg: st=%0d p=%b n=%b hi=%b run=%b err=%b want all 0", state_o, drv_p_o, drv_n_o, drv_hi_o, running_o, err_o); end
        en_i = 1'b0;
    endtask

    task automatic test_prechg_abort();
        @(negedge wb_clk_i);
        en_i = 1'b1;
        @(negedge wb_clk_i);
        for (int i = 0; i < 2; i++) do_tick();
        checks++; if (state_o !== S_PRE) begin errors++; $display("FAIL pa_prechg: got %0d want 1", state_o); end
        en_i = 1'b0;
        @(negedge wb_clk_i);
        checks++; if ({state_o, drv_p_o, drv_n_o, drv_hi_o} !== {S_OFF, 3'b000}) begin errors++; $display("FAIL pa_off: st=%0d p=%b n=%b hi=%b want all 0", state_o, drv_p_o, drv_n_o, drv_hi_o); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_underrun();
        test_ramp_reverse();
        test_reset_mid();
        test_prechg_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
